// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the IF requester, DM requester and memory-side handshake
//             signals of mem_arbiter into one interface.
//  Modports : slave  - arbiter view (requests/memory responses in, rest out)
//             master - environment view (requesters + memory model)
//  Signals  : if_req_i/if_addr_i/if_rsp_valid_o/if_rdata_o       fetch port
//             dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i/
//             dm_rsp_valid_o/dm_rdata_o                          data port
//             mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/
//             mem_gnt_i/mem_rvalid_i/mem_rdata_i                 memory side
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_rsp_valid_o;
  logic [DATA_W-1:0] if_rdata_o;
  // MEM-stage data port
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_rsp_valid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  // Memory side
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_rsp_valid_o, if_rdata_o,
    output dm_rsp_valid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_rsp_valid_o, if_rdata_o,
    input  dm_rsp_valid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-requester arbiter/sequencer in front of a single-ported
//             memory. Runs one transaction at a time (IDLE->REQ->WAIT->RESP)
//             and returns a registered one-cycle response pulse to the winner.
//  Ports    : clk_i         clock
//             rstn_i        asynchronous active-low reset
//             bus (slave)   IF/DM request + response ports, memory handshake
//  Options  : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are
//             granted to the port not granted last; otherwise DM beats IF.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        r_state;
  logic              r_win_dm;     // 1 = DM owns the in-flight transaction
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_rsp;
  logic              r_dm_rsp;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_any_req;
  logic              w_win_dm;

  assign w_any_req = bus.if_req_i | bus.dm_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant pointer: 0 = IF, 1 = DM. Resetting to IF lets DM win the
  // first conflict. Only consulted when both ports request together.
  logic r_last_dm;

  assign w_win_dm = (bus.dm_req_i && bus.if_req_i) ? ~r_last_dm : bus.dm_req_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_dm <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_dm <= w_win_dm;
    end
  end
`else
  assign w_win_dm = bus.dm_req_i;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_win_dm    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rsp    <= 1'b0;
      r_dm_rsp    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_win_dm  <= w_win_dm;
            r_mem_req <= 1'b1;
            if (w_win_dm) begin
              r_mem_we    <= bus.dm_we_i;
              r_mem_addr  <= bus.dm_addr_i;
              r_mem_wdata <= bus.dm_wdata_i;
            end else begin
              // Fetches are always reads with zero write data.
              r_mem_we    <= 1'b0;
              r_mem_addr  <= bus.if_addr_i;
              r_mem_wdata <= '0;
            end
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // An rvalid arriving before the grant belongs to nothing we issued.
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (r_win_dm) begin
              // Stores still get a response pulse, but with zero data.
              r_dm_rdata <= r_mem_we ? '0 : bus.mem_rdata_i;
              r_dm_rsp   <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata_i;
              r_if_rsp   <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_if_rsp <= 1'b0;
          r_dm_rsp <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_if_rsp  <= 1'b0;
          r_dm_rsp  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_o      = r_mem_req;
  assign bus.mem_we_o       = r_mem_we;
  assign bus.mem_addr_o     = r_mem_addr;
  assign bus.mem_wdata_o    = r_mem_wdata;
  assign bus.if_rsp_valid_o = r_if_rsp;
  assign bus.if_rdata_o     = r_if_rdata;
  assign bus.dm_rsp_valid_o = r_dm_rsp;
  assign bus.dm_rdata_o     = r_dm_rdata;

endmodule
`default_nettype wire
